// File: rtl/sdram_arbiter.sv
// sdram_arbiter
// Shares one single-port 8-bit SDRAM controller between port A (CPU) and
// port B (video/DMA). After reset it holds the controller in init, then
// issues a fixed number of refresh slots to step the power-up sequence.
// After that it raises ready and runs fixed-length slots, each granted to
// a pending refresh, port A or port B.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_din  port A request (level, held until a_ack)
//   a_dout, a_ack         port A read data (held) and one-cycle completion
//   b_*                   same as port A, for port B
//   ready                 init sequence complete
//   sd_init/sd_ce/sd_we/sd_refresh/sd_addr/sd_din  controller command side
//   sd_dout               controller read data
//
// state  | meaning
// S_HOLD | sd_init held high for INIT_HOLD clocks
// S_INIT | INIT_SLOTS back-to-back refresh slots, then ready
// S_IDLE | no slot running, arbitrate every clock
// S_SLOT | slot running, cnt = slot cycle c
module sdram_arbiter #(
  parameter int SLOT_LEN         = 10,
  parameter int DATA_LATCH       = 5,
  parameter int REFRESH_INTERVAL = 500,
  parameter int INIT_HOLD        = 16,
  parameter int INIT_SLOTS       = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [24:0] a_addr,
  input  logic [7:0]  a_din,
  output logic [7:0]  a_dout,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [24:0] b_addr,
  input  logic [7:0]  b_din,
  output logic [7:0]  b_dout,
  output logic        b_ack,
  output logic        ready,
  output logic        sd_init,
  output logic        sd_ce,
  output logic        sd_we,
  output logic        sd_refresh,
  output logic [24:0] sd_addr,
  output logic [7:0]  sd_din,
  input  logic [7:0]  sd_dout
);

  localparam int CNT_MAX = (INIT_HOLD > SLOT_LEN) ? INIT_HOLD : SLOT_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int ISL_W   = (INIT_SLOTS > 1) ? $clog2(INIT_SLOTS) : 1;
  localparam int RT_W    = $clog2(REFRESH_INTERVAL);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(INIT_HOLD - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_LEN - 1);
  localparam logic [CNT_W-1:0] ACK_C     = CNT_W'(SLOT_LEN - 2);
  localparam logic [CNT_W-1:0] LATCH_C   = CNT_W'(DATA_LATCH);
  localparam logic [ISL_W-1:0] ISL_LAST  = ISL_W'(INIT_SLOTS - 1);
  localparam logic [RT_W-1:0]  RT_LAST   = RT_W'(REFRESH_INTERVAL - 1);

  typedef enum logic [1:0] {S_HOLD, S_INIT, S_IDLE, S_SLOT} state_t;
  typedef enum logic [1:0] {K_NONE, K_REF, K_A, K_B} kind_t;

  state_t           state_q, state_d;
  kind_t            kind_q, kind_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ISL_W-1:0] isl_q, isl_d;
  logic [RT_W-1:0]  rt_q;
  logic             pend_q, last_b_q, last_b_d;
  logic             ready_d, arb, load, slot_hi;
  logic             sd_init_d, sd_ce_d, sd_we_d, sd_refresh_d, a_ack_d, b_ack_d;
  logic [24:0]      sd_addr_d;
  logic [7:0]       sd_din_d;

  // Refresh beats both ports; with both ports asking, the one not served last wins.
  always_comb begin
    win = K_NONE;
    if (ready) begin
      if (pend_q)                win = K_REF;
      else if (a_req && b_req)   win = last_b_q ? K_A : K_B;
      else if (a_req)            win = K_A;
      else if (b_req)            win = K_B;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    kind_d   = kind_q;
    isl_d    = isl_q;
    ready_d  = ready;
    last_b_d = last_b_q;
    arb      = 1'b0;
    load     = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_INIT: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d = '0;
          if (isl_q == ISL_LAST) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            isl_d = isl_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_IDLE: arb = 1'b1;
      S_SLOT: begin
        // Requests are only looked at on the last slot cycle, after the
        // winner has already seen its ack, so one request is granted once.
        if (cnt_q == SLOT_LAST) arb = 1'b1;
        else                    cnt_d = cnt_q + 1'b1;
      end
      default: state_d = S_HOLD;
    endcase

    if (arb) begin
      if (win != K_NONE) begin
        state_d = S_SLOT;
        cnt_d   = '0;
        kind_d  = win;
        load    = 1'b1;
        if (win == K_A)      last_b_d = 1'b0;
        else if (win == K_B) last_b_d = 1'b1;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Outputs are computed from the next state so they can be registered
    // and still line up with the slot cycle they belong to.
    slot_hi      = (cnt_d <= ACK_C);
    sd_init_d    = (state_d == S_HOLD);
    sd_refresh_d = slot_hi && ((state_d == S_INIT) ||
                               (state_d == S_SLOT && kind_d == K_REF));
    sd_ce_d      = slot_hi && (state_d == S_SLOT) && (kind_d == K_A || kind_d == K_B);
    a_ack_d      = (state_d == S_SLOT) && (kind_d == K_A) && (cnt_d == ACK_C);
    b_ack_d      = (state_d == S_SLOT) && (kind_d == K_B) && (cnt_d == ACK_C);
    sd_we_d      = (state_d == S_SLOT) ? sd_we : 1'b0;
    sd_addr_d    = sd_addr;
    sd_din_d     = sd_din;
    if (load) begin
      case (win)
        K_A: begin
          sd_we_d   = a_we;
          sd_addr_d = a_addr;
          sd_din_d  = a_din;
        end
        K_B: begin
          sd_we_d   = b_we;
          sd_addr_d = b_addr;
          sd_din_d  = b_din;
        end
        default: sd_we_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_HOLD;
      cnt_q      <= '0;
      kind_q     <= K_NONE;
      isl_q      <= '0;
      last_b_q   <= 1'b1;
      ready      <= 1'b0;
      sd_init    <= 1'b1;
      sd_ce      <= 1'b0;
      sd_we      <= 1'b0;
      sd_refresh <= 1'b0;
      sd_addr    <= '0;
      sd_din     <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      kind_q     <= kind_d;
      isl_q      <= isl_d;
      last_b_q   <= last_b_d;
      ready      <= ready_d;
      sd_init    <= sd_init_d;
      sd_ce      <= sd_ce_d;
      sd_we      <= sd_we_d;
      sd_refresh <= sd_refresh_d;
      sd_addr    <= sd_addr_d;
      sd_din     <= sd_din_d;
      a_ack      <= a_ack_d;
      b_ack      <= b_ack_d;
    end
  end

  // Refresh timer runs from ready; pending clears when its slot is granted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rt_q   <= '0;
      pend_q <= 1'b0;
    end else if (ready) begin
      if (rt_q == RT_LAST) begin
        rt_q   <= '0;
        pend_q <= 1'b1;
      end else begin
        rt_q <= rt_q + 1'b1;
        if (load && win == K_REF) pend_q <= 1'b0;
      end
    end
  end

  // Read data is stable well before this cycle; writes leave dout untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else if (state_q == S_SLOT && cnt_q == LATCH_C && !sd_we) begin
      if (kind_q == K_A) a_dout <= sd_dout;
      if (kind_q == K_B) b_dout <= sd_dout;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
module tb_sdram_arbiter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [24:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_din = '0, b_din = '0;
  logic [7:0]  a_dout, b_dout, sd_din, sd_dout;
  logic        a_ack, b_ack, ready, sd_init, sd_ce, sd_we, sd_refresh;
  logic [24:0] sd_addr;

  int checks = 0, failures = 0, cyc = 0, t_r = 0;
  int n, rh, ch, wh, in_n, rise, acks, total, refs, first_ref, second_ref, ok;
  logic ga, gb;
  logic [24:0] cap_addr;
  logic [7:0]  exp_d;

  // Controller stand-in: unwritten bytes read as (addr low byte ^ 0x5A).
  logic [7:0]   mem [256];
  logic [255:0] wr_valid = '0;

  sdram_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(a_dout), .a_ack(a_ack),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_dout(b_dout), .b_ack(b_ack),
    .ready(ready), .sd_init(sd_init), .sd_ce(sd_ce), .sd_we(sd_we), .sd_refresh(sd_refresh),
    .sd_addr(sd_addr), .sd_din(sd_din), .sd_dout(sd_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sd_ce && sd_we) begin
      mem[sd_addr[7:0]]      <= sd_din;
      wr_valid[sd_addr[7:0]] <= 1'b1;
    end
  end
  assign sd_dout = wr_valid[sd_addr[7:0]] ? mem[sd_addr[7:0]] : (sd_addr[7:0] ^ 8'h5A);

  initial begin
    #400000;
    $display("FAIL watchdog expired cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_flags"}, 32'({sd_init, sd_ce, sd_we, sd_refresh, a_ack, b_ack, ready}), 32'h40);
    check({tag, "_addr"}, 32'(sd_addr), 32'h0);
    check({tag, "_din"}, 32'(sd_din), 32'h0);
    check({tag, "_douts"}, 32'({a_dout, b_dout}), 32'h0);
  endtask

  task automatic wait_ack(input int limit, output int cnt, output logic got_a, output logic got_b,
                          output int ref_hi, output int ce_hi, output int we_hi);
    cnt = 0; got_a = 1'b0; got_b = 1'b0; ref_hi = 0; ce_hi = 0; we_hi = 0;
    while (!got_a && !got_b && cnt < limit) begin
      @(negedge clk);
      cnt++;
      if (sd_refresh) ref_hi++;
      if (sd_ce) ce_hi++;
      if (sd_we) we_hi++;
      got_a = a_ack;
      got_b = b_ack;
    end
    if (!got_a && !got_b) begin
      checks++;
      failures++;
      $error("FAIL ack_timeout waited=%0d required_within=%0d", cnt, limit);
    end
  endtask

  // Called at the negedge where reset_n is released; returns at the first
  // negedge that sees ready high.
  task automatic verify_init(output int init_n, output int cnt, output int rises, output int hi,
                             output int ce_n, output int ack_n);
    logic prev;
    init_n = 0; cnt = 0; rises = 0; hi = 0; ce_n = 0; ack_n = 0; prev = 1'b0;
    while (sd_init && init_n < 100) begin
      init_n++;
      @(negedge clk);
    end
    while (!ready && cnt < 1000) begin
      if (sd_refresh && !prev) rises++;
      if (sd_refresh) hi++;
      if (sd_ce) ce_n++;
      if (a_ack || b_ack) ack_n++;
      prev = sd_refresh;
      cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset state and init sequence
    repeat (3) @(negedge clk);
    check_reset_vals("rst");
    reset_n = 1'b1;
    verify_init(in_n, n, rise, rh, ch, acks);
    check("init_hold_clocks", 32'(in_n), 32'd16);
    check("init_slot_clocks", 32'(n), 32'd320);
    check("init_refresh_pulses", 32'(rise), 32'd32);
    check("init_refresh_high", 32'(rh), 32'd288);
    check("init_ce_high", 32'(ch), 32'd0);
    check("init_ready", 32'(ready), 32'd1);
    t_r = cyc;

    // A write then A read of the same address
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 25'h0012345; a_din = 8'hA5;
    wait_ack(40, n, ga, gb, rh, ch, wh);
    cap_addr = sd_addr;
    a_req = 1'b0; a_we = 1'b0;
    check("wr_latency", 32'(n), 32'd9);
    check("wr_ack_port", 32'({ga, gb}), 32'b10);
    check("wr_addr", 32'(cap_addr), 32'h0012345);
    check("wr_ce_high", 32'(ch), 32'd9);
    @(negedge clk);
    if (sd_we) wh++;
    check("wr_we_high", 32'(wh), 32'd10);
    @(negedge clk);
    check("wr_we_dropped", 32'(sd_we), 32'd0);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0012345;
    wait_ack(40, n, ga, gb, rh, ch, wh);
    a_req = 1'b0;
    check("rd_latency", 32'(n), 32'd9);
    check("rd_ack_port", 32'({ga, gb}), 32'b10);
    check("rd_data", 32'(a_dout), 32'hA5);
    check("rd_we_high", 32'(wh), 32'd0);

    // Both ports request continuously: A was served last, so B goes first
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000011;
    b_req = 1'b1; b_we = 1'b0; b_addr = 25'h1ABCD22;
    for (int k = 0; k < 6; k++) begin
      wait_ack(40, n, ga, gb, rh, ch, wh);
      check("rr_latency", 32'(n), (k == 0) ? 32'd9 : 32'd10);
      check("rr_ack_port", 32'({ga, gb}), (k % 2 == 0) ? 32'b01 : 32'b10);
      if (gb) check("rr_b_data", 32'(b_dout), 32'h78);
      else    check("rr_a_data", 32'(a_dout), 32'h4B);
    end
    a_req = 1'b0; b_req = 1'b0;

    // Refresh timer expires during a B slot (pending from ready + 500)
    while (cyc < t_r + 490) @(negedge clk);
    b_req = 1'b1; b_we = 1'b0; b_addr = 25'h1ABCD22;
    wait_ack(40, n, ga, gb, rh, ch, wh);
    cap_addr = sd_addr;
    check("ref_b_latency", 32'(n), 32'd9);
    check("ref_b_port", 32'({ga, gb}), 32'b01);
    check("ref_b_addr", 32'(cap_addr), 32'h1ABCD22);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000011;
    wait_ack(40, n, ga, gb, rh, ch, wh);
    a_req = 1'b0;
    check("ref_then_a_port", 32'({ga, gb}), 32'b10);
    check("ref_then_a_gap", 32'(n), 32'd20);
    check("ref_refresh_high", 32'(rh), 32'd9);
    check("ref_ce_high", 32'(ch), 32'd9);
    wait_ack(40, n, ga, gb, rh, ch, wh);
    b_req = 1'b0;
    check("ref_then_b_port", 32'({ga, gb}), 32'b01);
    check("ref_then_b_gap", 32'(n), 32'd10);
    check("ref_then_b_no_refresh", 32'(rh), 32'd0);

    // Reset at c=4 of a read slot, both ports left requesting
    while (cyc < t_r + 540) @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 25'h0000011;
    b_req = 1'b1; b_we = 1'b0; b_addr = 25'h1ABCD22;
    repeat (5) @(negedge clk);
    check("mid_slot_ce", 32'(sd_ce), 32'd1);
    check("mid_slot_a_dout", 32'(a_dout), 32'h4B);
    reset_n = 1'b0;
    #1;
    check_reset_vals("abort");
    repeat (3) @(negedge clk);
    check_reset_vals("abort_hold");
    reset_n = 1'b1;
    verify_init(in_n, n, rise, rh, ch, acks);
    check("reinit_hold_clocks", 32'(in_n), 32'd16);
    check("reinit_slot_clocks", 32'(n), 32'd320);
    check("reinit_refresh_pulses", 32'(rise), 32'd32);
    check("reinit_ce_high", 32'(ch), 32'd0);
    check("reinit_acks", 32'(acks), 32'd0);
    wait_ack(40, n, ga, gb, rh, ch, wh);
    a_req = 1'b0;
    check("post_reset_first_port", 32'({ga, gb}), 32'b10);
    check("post_reset_latency", 32'(n), 32'd9);
    check("post_reset_a_data", 32'(a_dout), 32'h4B);
    wait_ack(40, n, ga, gb, rh, ch, wh);
    check("post_reset_second_port", 32'({ga, gb}), 32'b01);
    check("post_reset_b_data", 32'(b_dout), 32'h78);

    // B alone: 100 back-to-back reads, refresh before reads 49 and 98
    b_addr = 25'h1000001;
    total = 0; refs = 0; first_ref = 0; second_ref = 0; ok = 0;
    for (int i = 1; i <= 100; i++) begin
      wait_ack(40, n, ga, gb, rh, ch, wh);
      total += n;
      if (gb && !ga && ((n == 10 && rh == 0) || (n == 20 && rh == 9))) ok++;
      if (rh == 9) begin
        refs++;
        if (refs == 1) first_ref = i;
        else if (refs == 2) second_ref = i;
      end
      exp_d = (i == 69) ? 8'hA5 : (8'(i) ^ 8'h5A);
      check("b2b_data", 32'(b_dout), 32'(exp_d));
      if (i < 100) b_addr = 25'h1000000 + 25'(i + 1);
      else         b_req = 1'b0;
    end
    check("b2b_slots_ok", 32'(ok), 32'd100);
    check("b2b_total_clocks", 32'(total), 32'd1020);
    check("b2b_refresh_count", 32'(refs), 32'd2);
    check("b2b_first_refresh", 32'(first_ref), 32'd49);
    check("b2b_second_refresh", 32'(second_ref), 32'd98);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
